// File: rtl/channel_read_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------------------------
// channel_read_arbiter
//
// Round-robin scheduler sharing one channel read port among NUM_REQ reduce engines. Each grant
// is a fixed burst of BURST pops from the channel. Every popped word is forwarded on rd_data
// with a one-hot rd_valid strobe that names the granted engine. A one-hot done pulse closes
// the burst.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-low reset
//   req            per-engine request level, only looked at while idle
//   gnt            registered one-hot grant, held for the whole burst
//   rd_data        registered copy of the last popped word
//   rd_valid       one-hot, one-cycle strobe qualifying rd_data for the granted engine
//   done           one-hot, one-cycle pulse marking the end of the granted burst
//   busy           high while a burst is in flight (XFER or DONE)
//   ch_read_valid  pop strobe to the channel
//   ch_rst         active-high channel reset, the inverse of rst
//   ch_out_data    channel head word
//   ch_read_ready  channel holds at least one word
// ---------------------------------------------------------------------------------------------
module channel_read_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BURST   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rd_data,
  output logic [NUM_REQ-1:0] rd_valid,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic               ch_read_valid,
  output logic               ch_rst,
  input  logic [WIDTH-1:0]   ch_out_data,
  input  logic               ch_read_ready
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // One spare bit so rr_ptr + offset never overflows before the modulo fold.
  localparam logic [IdxW:0]   NumReqW  = (IdxW + 1)'(NUM_REQ);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);
  localparam logic [7:0]      LastBeat = 8'(BURST - 1);

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]    gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic               pop;
  logic               pick_found;
  logic [IdxW-1:0]    pick_idx;
  logic [IdxW:0]      scan;

  // -------------------------------------------------------------------------------------------
  // Round-robin pick: first requester found walking rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  // -------------------------------------------------------------------------------------------
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
      if (scan >= NumReqW) begin
        scan = scan - NumReqW;
      end
      if (!pick_found && req[scan[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[IdxW-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    rd_data_d  = rd_data_q;
    // Strobes are single-cycle unless re-armed below.
    rd_valid_d = '0;
    done_d     = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StXfer;
          gnt_d             = '0;
          gnt_d[pick_idx]   = 1'b1;
          gnt_idx_d         = pick_idx;
          beat_cnt_d        = '0;
        end
      end

      StXfer: begin
        if (pop) begin
          rd_data_d  = ch_out_data;
          rd_valid_d = gnt_q;
          beat_cnt_d = beat_cnt_q + 8'd1;
          // done is registered here so it lands in the DONE cycle together with the last
          // word's rd_valid.
          if (beat_cnt_q == LastBeat) begin
            state_d = StDone;
            done_d  = gnt_q;
          end
        end
      end

      StDone: begin
        state_d  = StIdle;
        gnt_d    = '0;
        rr_ptr_d = (gnt_idx_q == LastIdx) ? '0 : gnt_idx_q + IdxW'(1);
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  always_comb begin
    // Qualifying with rst stops a pop in the cycle a reset is pending, since that word would
    // be thrown away by the reset edge.
    ch_read_valid = rst && (state_q == StXfer) && ch_read_ready;
    pop           = ch_read_valid;
    busy          = rst && (state_q != StIdle);
    ch_rst        = !rst;
  end

  assign gnt      = gnt_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_channel_read_arbiter.sv
`timescale 1ns/1ps
module tb_channel_read_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic [3:0] gnt;
    logic [3:0] rv;
    logic [3:0] done;
    logic       crv;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0]  eng;
    logic [31:0] data;
  } sb_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] rd_data;
  logic [3:0]  rd_valid;
  logic [3:0]  done;
  logic        busy;
  logic        ch_read_valid;
  logic        ch_rst;
  logic [31:0] ch_out_data;
  logic        ch_read_ready;

  logic [31:0] word;
  vec_t        vecs[$];
  sb_t         sbq[$];
  int          tests;
  int          fails;

  assign ch_out_data = word;

  channel_read_arbiter #(
    .NUM_REQ(4),
    .WIDTH  (32),
    .BURST  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .gnt          (gnt),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .done         (done),
    .busy         (busy),
    .ch_read_valid(ch_read_valid),
    .ch_rst       (ch_rst),
    .ch_out_data  (ch_out_data),
    .ch_read_ready(ch_read_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rs, input logic [3:0] rq, input logic rd, input logic [3:0] g,
                     input logic [3:0] rv, input logic [3:0] dn, input logic crv,
                     input logic bsy);
    vec_t v;
    v.rst = rs; v.req = rq; v.ready = rd; v.gnt = g; v.rv = rv; v.done = dn;
    v.crv = crv; v.busy = bsy;
    vecs.push_back(v);
  endtask

  // One IDLE cycle, BURST always-ready XFER cycles, then DONE.
  task automatic burst(input logic [3:0] req_idle, input logic [3:0] req_after,
                       input logic [3:0] g);
    add(1'b1, req_idle, 1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      add(1'b1, (k == 0) ? req_idle : req_after, 1'b1, g, (k == 0) ? 4'b0 : g, 4'b0, 1'b1,
          1'b1);
    end
    add(1'b1, req_after, 1'b1, g, g, g, 1'b0, 1'b1);
  endtask

  initial begin
    vec_t        v;
    sb_t         e;
    logic        pop_now;
    logic        prev_rst;
    logic [14:0] act;
    logic [14:0] exp_v;
    logic [3:0]  cont_g[5];

    tests = 0;
    fails = 0;
    word  = 32'd10;
    rst   = 1'b0;
    req   = 4'b0;
    ch_read_ready = 1'b0;

    // Reset state
    add(1'b0, 4'b1111, 1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    // Single requester, words 10..13; leaves rr_ptr at 2
    burst(4'b0010, 4'b0010, 4'b0010);
    // rr_ptr=2 must favour index 2 over 0 and 1
    burst(4'b0111, 4'b0111, 4'b0100);
    // Reset in IDLE brings rr_ptr back to 0
    add(1'b0, 4'b1111, 1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    // Contention with all requests held
    cont_g[0] = 4'b0001; cont_g[1] = 4'b0010; cont_g[2] = 4'b0100;
    cont_g[3] = 4'b1000; cont_g[4] = 4'b0001;
    for (int b = 0; b < 5; b++) burst(4'b1111, 4'b1111, cont_g[b]);
    // Grant index 3 wraps the pointer to 0, then req[0] beats req[3]
    burst(4'b1000, 4'b1001, 4'b1000);
    burst(4'b1001, 4'b1001, 4'b0001);
    // req[2] drops after the first pop; burst still completes (rr_ptr was 1)
    burst(4'b0100, 4'b0000, 4'b0100);
    // Channel stalls 1,0,0,1,1,0,1 (rr_ptr was 3, scan reaches index 0)
    add(1'b1, 4'b0001, 1'b1, 4'b0,    4'b0,    4'b0,    1'b0, 1'b0);
    add(1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0,    4'b0,    1'b1, 1'b1);
    add(1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0,    1'b0, 1'b1);
    add(1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0,    4'b0,    1'b0, 1'b1);
    add(1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0,    4'b0,    1'b1, 1'b1);
    add(1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0,    1'b1, 1'b1);
    add(1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0,    1'b0, 1'b1);
    add(1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0,    4'b0,    1'b1, 1'b1);
    add(1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1);
    // Reset one cycle after the 2nd pop of a burst to engine 1
    add(1'b1, 4'b0010, 1'b1, 4'b0,    4'b0,    4'b0,    1'b0, 1'b0);
    add(1'b1, 4'b0010, 1'b1, 4'b0010, 4'b0,    4'b0,    1'b1, 1'b1);
    add(1'b1, 4'b0010, 1'b1, 4'b0010, 4'b0010, 4'b0,    1'b1, 1'b1);
    add(1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0010, 4'b0,    1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 4'b0,    4'b0,    4'b0,    1'b0, 1'b0);
    // Fresh burst; rr_ptr back at 0 so index 0 beats index 1
    burst(4'b0011, 4'b0011, 4'b0001);
    add(1'b1, 4'b0000, 1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    prev_rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      rst = v.rst;
      req = v.req;
      ch_read_ready = v.ready;
      #2;

      act   = {gnt, rd_valid, done, ch_read_valid, busy, ch_rst};
      exp_v = {v.gnt, v.rv, v.done, v.crv, v.busy, ~v.rst};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL row %0d: got gnt=%b rv=%b done=%b crv=%b busy=%b ch_rst=%b, want gnt=%b rv=%b done=%b crv=%b busy=%b ch_rst=%b",
                 r, gnt, rd_valid, done, ch_read_valid, busy, ch_rst,
                 v.gnt, v.rv, v.done, v.crv, v.busy, ~v.rst);
      end

      if (!prev_rst) begin
        tests++;
        if (rd_data !== 32'd0) begin
          fails++;
          $display("FAIL rd_data_reset row %0d: got %0d want 0", r, rd_data);
        end
      end

      if (rd_valid !== 4'b0) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected row %0d: got rv=%b data=%0d, want no word", r, rd_valid,
                   rd_data);
        end else begin
          e = sbq.pop_front();
          if (rd_valid !== e.eng || rd_data !== e.data) begin
            fails++;
            $display("FAIL sb_word row %0d: got rv=%b data=%0d, want rv=%b data=%0d", r,
                     rd_valid, rd_data, e.eng, e.data);
          end
        end
      end

      pop_now  = ch_read_valid;
      prev_rst = v.rst;
      @(posedge clk);
      #1;
      if (pop_now === 1'b1) begin
        e.eng  = v.gnt;
        e.data = word;
        sbq.push_back(e);
        word = word + 32'd1;
      end
    end

    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d undelivered words, want 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/channel_read_arbiter.md
# channel_read_arbiter

Round-robin scheduler that shares one channel read port among NUM_REQ channel-reduce engines. Each grant is a fixed burst of BURST pops. Popped words are forwarded to the granted engine with a one-hot valid strobe, and a done pulse closes the burst. The block sits between a single input channel instance and a bank of reduce datapaths, so several reductions can consume one stream without contending on read_valid.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..8.
- WIDTH, default 32: channel data width.
- BURST, default 4: pops per grant; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-low (the block is in reset while rst==0).
- req  in  NUM_REQ  per-engine request level; sampled only in IDLE.
- gnt  out  NUM_REQ  one-hot grant, registered; held for the whole burst.
- rd_data  out  WIDTH  last popped word, registered.
- rd_valid  out  NUM_REQ  one-hot, one-cycle strobe marking rd_data for the granted engine.
- done  out  NUM_REQ  one-hot, one-cycle pulse when the granted burst completes.
- busy  out  1  high in XFER and DONE.
- ch_read_valid  out  1  pop strobe to the channel.
- ch_rst  out  1  active-high channel reset, equal to !rst.
- ch_out_data  in  WIDTH  channel head word.
- ch_read_ready  in  1  channel has data.

## Operation
- States: IDLE, XFER, DONE. Registers: gnt, rr_ptr (index of the highest-priority requester), beat_cnt (8 bits), rd_data, rd_valid, done.
- Reset (rst==0 at a clock edge):
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - gnt, rd_valid, done = 0; rd_data = 0.
  - Outputs: ch_read_valid=0, ch_rst=1, busy=0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Set gnt to that one-hot bit, beat_cnt=0, and go to XFER.
- XFER:
  - ch_read_valid = ch_read_ready, combinational, gated by state==XFER.
  - A pop happens in any cycle with ch_read_valid==1.
  - On a pop: rd_data <= ch_out_data, rd_valid <= gnt, beat_cnt <= beat_cnt+1.
  - A pop with beat_cnt==BURST-1 moves the block to DONE.
  - With no pop, rd_valid <= 0 and all other state holds.
- DONE:
  - done = gnt for exactly this cycle.
  - rr_ptr <= (granted index+1) mod NUM_REQ; gnt <= 0; return to IDLE.
- req is ignored outside IDLE. Once granted, a burst always runs to BURST pops, even if the requester drops req.
- No pop occurs in IDLE or DONE, even when ch_read_ready==1.
- gnt, rd_valid and done are never multi-hot, and rd_valid/done never fire for a non-granted engine.

## Timing
- Request to grant: req seen in IDLE at edge t gives gnt high after t. The first pop is possible in cycle t+1.
- Each word has one cycle of latency: rd_valid[i] and rd_data appear the cycle after the pop.
- Minimum burst length is BURST+2 cycles (XFER×BURST, DONE, IDLE). Each channel stall cycle (ch_read_ready==0 in XFER) adds one cycle.
- The final word's rd_valid coincides with done in the DONE cycle. gnt falls at the edge ending DONE.
- Between grants there are always 2 cycles with no pop (DONE, IDLE).
- Wrap-around: rr_ptr = NUM_REQ-1 followed by a grant to index NUM_REQ-1 sets rr_ptr=0.
- Reset mid-burst takes effect at the next edge: the burst is abandoned with no done pulse, and ch_read_valid drops that same cycle.

## Test plan
- Single requester, always-ready channel:
  - Stimulus: req=4'b0010, channel words 10,11,12,13.
  - Response: gnt=0010 after 1 cycle, 4 consecutive rd_valid=0010 with rd_data 10..13, done=0010 with the 4th, then rr_ptr=2.
- Contention:
  - Stimulus: req=4'b1111 held.
  - Response: grants in order 0001, 0010, 0100, 1000, 0001, each burst separated by exactly 2 pop-free cycles.
- Channel stalls:
  - Stimulus: ch_read_ready toggles 1,0,0,1,1,0,1 during a burst.
  - Response: exactly 4 pops, burst takes 7 XFER cycles, ch_read_valid never high while ready==0.
- Request drop:
  - Stimulus: req[2] deasserts after the first pop.
  - Response: the burst still completes 4 pops and done=0100.
- Reset mid-burst:
  - Stimulus: rst=0 for one cycle after the 2nd pop.
  - Response: next cycle gnt=0, rd_valid=0, done=0, ch_read_valid=0, rr_ptr=0; the next req=0001 restarts a fresh 4-beat burst.
- Pointer wrap:
  - Stimulus: NUM_REQ=4 with only req[3], then req=1001.
  - Response: req[3] is granted, then req[0] wins over req[3].
